// File: rtl/fp16_mult_arbiter_if.sv
// Bundle of the requester, response and multiplier channels around fp16_mult_arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding environment's view.
interface fp16_mult_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [16*N_REQ-1:0] req_a;
    logic [16*N_REQ-1:0] req_b;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [15:0]         rsp_result;
    logic                rsp_overflow;
    logic                rsp_underflow;
    logic                rsp_nan;

    logic                busy;

    logic                mul_clk_en;
    logic [15:0]         mul_dataa;
    logic [15:0]         mul_datab;
    logic [15:0]         mul_result;
    logic                mul_overflow;
    logic                mul_underflow;
    logic                mul_nan;

    modport master (
        input  req_valid, req_a, req_b,
        output req_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow, rsp_nan,
        input  rsp_ready,
        output busy,
        output mul_clk_en, mul_dataa, mul_datab,
        input  mul_result, mul_overflow, mul_underflow, mul_nan
    );

    modport slave (
        output req_valid, req_a, req_b,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow, rsp_nan,
        output rsp_ready,
        input  busy,
        input  mul_clk_en, mul_dataa, mul_datab,
        output mul_result, mul_overflow, mul_underflow, mul_nan
    );
endinterface

// File: rtl/fp16_mult_arbiter.sv
// Round-robin sharing of one non-pipelined FP16 multiplier among N_REQ requesters:
// grant and issue in IDLE, wait out LATENCY cycles, then hold the result until consumed.
module fp16_mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    fp16_mult_arbiter_if.master  bus
);

    localparam int IW    = ID_W + 1;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_cur_id;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [15:0]      r_rsp_result;
    logic             r_rsp_overflow;
    logic             r_rsp_underflow;
    logic             r_rsp_nan;

    logic             w_grant_valid;
    logic [ID_W-1:0]  w_grant_id;
    logic [15:0]      w_req_a [N_REQ];
    logic [15:0]      w_req_b [N_REQ];

    // (base + off) mod N_REQ, for any N_REQ in 2..8 (not only powers of two).
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        logic [IW-1:0] sum;
        sum = {1'b0, base} + IW'(off);
        if (sum >= IW'(N_REQ)) begin
            sum = sum - IW'(N_REQ);
        end
        return sum[ID_W-1:0];
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_req_a[i] = bus.req_a[16*i +: 16];
        assign w_req_b[i] = bus.req_b[16*i +: 16];
    end

    // Winner search starts at r_rr_ptr; the reset term keeps every grant output low while reset is held.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        w_grant_valid = 1'b0;
        w_grant_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_grant_valid && bus.req_valid[wrap_add(r_rr_ptr, k)]) begin
                w_grant_valid = 1'b1;
                w_grant_id    = wrap_add(r_rr_ptr, k);
            end
        end
        if ((r_state != S_IDLE) || !reset) begin
            w_grant_valid = 1'b0;
        end
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.mul_clk_en = w_grant_valid;
        bus.mul_dataa  = '0;
        bus.mul_datab  = '0;
        if (w_grant_valid) begin
            bus.req_ready[w_grant_id] = 1'b1;
            bus.mul_dataa             = w_req_a[w_grant_id];
            bus.mul_datab             = w_req_b[w_grant_id];
        end
    end

    // NOTE: reset is asynchronous active-low; sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_rr_ptr        <= '0;
            r_cur_id        <= '0;
            r_cnt           <= '0;
            r_busy          <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_id        <= '0;
            r_rsp_result    <= '0;
            r_rsp_overflow  <= 1'b0;
            r_rsp_underflow <= 1'b0;
            r_rsp_nan       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_cur_id <= w_grant_id;
                        r_rr_ptr <= wrap_add(w_grant_id, 1);
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_rsp_valid     <= 1'b1;
                        r_rsp_id        <= r_cur_id;
                        r_rsp_result    <= bus.mul_result;
                        r_rsp_overflow  <= bus.mul_overflow;
                        r_rsp_underflow <= bus.mul_underflow;
                        r_rsp_nan       <= bus.mul_nan;
                        r_state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    // No grant in the handshake cycle: the next arbitration happens back in IDLE.
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_id        = r_rsp_id;
    assign bus.rsp_result    = r_rsp_result;
    assign bus.rsp_overflow  = r_rsp_overflow;
    assign bus.rsp_underflow = r_rsp_underflow;
    assign bus.rsp_nan       = r_rsp_nan;
    assign bus.busy          = r_busy;

endmodule

// File: tb/tb_fp16_mult_arbiter.sv
// Self-checking bench: an FP16 multiplier stub with a LATENCY-deep pipeline, and a cycle-timeline
// reference of the arbiter (round-robin pointer, one outstanding op, response due at grant+LATENCY+1).
module tb_fp16_mult_arbiter;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int LATENCY = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fp16_mult_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    fp16_mult_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .LATENCY(LATENCY)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // IEEE754 half multiply with round-to-nearest-even; returns {overflow, underflow, nan, result}.
    function automatic longint rne(input longint p, input int sh);
        longint q, rem, half;
        if (sh <= 0) return p <<< (-sh);
        if (sh >= 62) return 0;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        return q;
    endfunction

    function automatic logic [18:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic   s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        longint ma, mb, p, m;
        int     ea, eb, e, n, top;
        s      = a[15] ^ b[15];
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        a_zero = (a[14:0] == 0);
        b_zero = (b[14:0] == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {3'b001, 16'h7E00};
        if (a_inf || b_inf) return {3'b000, s, 15'h7C00};
        if (a_zero || b_zero) return {3'b000, s, 15'h0000};
        ma = (a[14:10] == 0) ? longint'(a[9:0]) : longint'({1'b1, a[9:0]});
        mb = (b[14:10] == 0) ? longint'(b[9:0]) : longint'({1'b1, b[9:0]});
        ea = (a[14:10] == 0) ? -24 : int'(a[14:10]) - 25;
        eb = (b[14:10] == 0) ? -24 : int'(b[14:10]) - 25;
        p  = ma * mb;
        e  = ea + eb;
        n  = 0;
        for (int i = 0; i < 24; i++) if (p[i]) n = i;
        top = n + e;
        if (top > 15) return {3'b100, s, 15'h7C00};
        if (top >= -14) begin
            m = rne(p, n - 10);
            if (m == 2048) begin
                m   = 1024;
                top = top + 1;
            end
            if (top > 15) return {3'b100, s, 15'h7C00};
            return {3'b000, s, 5'(top + 15), m[9:0]};
        end
        m = rne(p, -24 - e);
        return {3'b010, s, m[14:0]};
    endfunction

    // Multiplier stub: LATENCY-deep pipeline; bubbles present a poison pattern with all flags set.
    logic [15:0] stg_res [LATENCY];
    logic [2:0]  stg_fl  [LATENCY];
    logic        stg_vld [LATENCY];
    logic [18:0] stub_prod;
    assign stub_prod = fp16_mul(bus.mul_dataa, bus.mul_datab);

    always @(posedge clock) begin
        for (int s = LATENCY - 1; s > 0; s--) begin
            stg_res[s] <= stg_res[s-1];
            stg_fl[s]  <= stg_fl[s-1];
            stg_vld[s] <= stg_vld[s-1];
        end
        stg_res[0] <= stub_prod[15:0];
        stg_fl[0]  <= stub_prod[18:16];
        stg_vld[0] <= bus.mul_clk_en;
    end

    assign bus.mul_result = stg_vld[LATENCY-1] ? stg_res[LATENCY-1] : 16'hDEAD;
    assign {bus.mul_overflow, bus.mul_underflow, bus.mul_nan} = stg_vld[LATENCY-1] ? stg_fl[LATENCY-1] : 3'b111;

    // Reference timeline state.
    bit          m_out;
    int          m_t0, m_due, m_id, m_ptr, cyc;
    logic [15:0] m_res;
    logic [2:0]  m_fl;
    logic [N_REQ-1:0] refill;

    typedef struct {
        int          id;
        logic [15:0] res;
        logic [2:0]  fl;
        int          cyc;
    } rsp_t;
    rsp_t rsp_log[$];
    int   grant_id_log[$];
    int   grant_cyc_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[16*i +: 16] = a;
        bus.req_b[16*i +: 16] = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_mul_clk_en"}, bus.mul_clk_en, 0);
        check({tag, "_mul_dataa"}, bus.mul_dataa, 0);
        check({tag, "_mul_datab"}, bus.mul_datab, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_id"}, bus.rsp_id, 0);
        check({tag, "_rsp_result"}, bus.rsp_result, 0);
        check({tag, "_rsp_flags"}, {bus.rsp_overflow, bus.rsp_underflow, bus.rsp_nan}, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    // One clock cycle: called at a falling edge after inputs are set; compares, then consumes grants.
    task automatic tick();
        int g;
        logic [N_REQ-1:0] exp_rdy;
        bit exp_rv, hs;
        logic [18:0] prod;
        #1;
        g       = -1;
        exp_rdy = '0;
        if (!m_out) begin
            for (int k = 0; k < N_REQ; k++) begin
                int idx;
                idx = (m_ptr + k) % N_REQ;
                if (g < 0 && bus.req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", bus.req_ready, exp_rdy);
        check("mul_clk_en", bus.mul_clk_en, 32'(g >= 0));
        check("mul_dataa", bus.mul_dataa, (g >= 0) ? bus.req_a[16*g +: 16] : 16'h0);
        check("mul_datab", bus.mul_datab, (g >= 0) ? bus.req_b[16*g +: 16] : 16'h0);
        exp_rv = m_out && (cyc >= m_due);
        check("rsp_valid", bus.rsp_valid, exp_rv);
        check("busy", bus.busy, 32'(m_out && (cyc > m_t0)));
        if (exp_rv) begin
            check("rsp_id", bus.rsp_id, m_id);
            check("rsp_result", bus.rsp_result, m_res);
            check("rsp_flags", {bus.rsp_overflow, bus.rsp_underflow, bus.rsp_nan}, m_fl);
        end
        hs = exp_rv && bus.rsp_ready;
        if (hs) rsp_log.push_back('{int'(bus.rsp_id), bus.rsp_result,
                                    {bus.rsp_overflow, bus.rsp_underflow, bus.rsp_nan}, cyc});
        if (g >= 0) begin
            prod  = fp16_mul(bus.req_a[16*g +: 16], bus.req_b[16*g +: 16]);
            m_out = 1'b1;
            m_t0  = cyc;
            m_due = cyc + LATENCY + 1;
            m_id  = g;
            m_res = prod[15:0];
            m_fl  = prod[18:16];
            m_ptr = (g + 1) % N_REQ;
            grant_id_log.push_back(g);
            grant_cyc_log.push_back(cyc);
        end
        @(negedge clock);
        if (hs) m_out = 1'b0;
        if (g >= 0) begin
            if (refill[g]) set_op(g, 16'($urandom), 16'($urandom));
            else bus.req_valid[g] = 1'b0;
        end
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && m_out; i++) tick();
        check("drain_done", m_out, 0);
    endtask

    task automatic wait_grants(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && grant_id_log.size() < n; i++) tick();
        check(tag, 32'(grant_id_log.size() >= n), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        refill        = '0;
        m_out = 1'b0; m_t0 = 0; m_due = 0; m_id = 0; m_ptr = 0; cyc = 0;
        m_res = '0; m_fl = '0;

        // Reset with every requester pending: all outputs must stay low.
        repeat (2) @(negedge clock);
        for (int i = 0; i < N_REQ; i++) set_op(i, 16'($urandom), 16'($urandom));
        bus.req_valid = '1;
        #1;
        check_all_zero("reset");

        // All requesters continuously active: order 0,1,2,3,0 at 10-cycle spacing.
        @(negedge clock);
        reset  = 1'b1;
        refill = '1;
        wait_grants("rr_grants_seen", 5, 80);
        bus.req_valid = '0;
        refill        = '0;
        for (int i = 0; i < 5 && i < grant_id_log.size(); i++) begin
            check("rr_order", grant_id_log[i], i % N_REQ);
            if (i > 0) check("rr_spacing", grant_cyc_log[i] - grant_cyc_log[i-1], LATENCY + 2);
        end
        drain();

        // Single request from requester 2: 1.0 * 2.0.
        n0 = grant_id_log.size();
        rsp_log.delete();
        set_op(2, 16'h3C00, 16'h4000);
        bus.req_valid[2] = 1'b1;
        for (int i = 0; i < 30 && rsp_log.size() == 0; i++) tick();
        check("single_rsp_seen", rsp_log.size(), 1);
        if (rsp_log.size() > 0 && grant_id_log.size() > n0) begin
            check("single_grant_id", grant_id_log[n0], 2);
            check("single_rsp_id", rsp_log[0].id, 2);
            check("single_result", rsp_log[0].res, 16'h4000);
            check("single_flags", rsp_log[0].fl, 3'b000);
            check("single_latency", rsp_log[0].cyc - grant_cyc_log[n0], LATENCY + 1);
        end

        // Overflow: largest finite half squared.
        rsp_log.delete();
        set_op(1, 16'h7BFF, 16'h7BFF);
        bus.req_valid[1] = 1'b1;
        for (int i = 0; i < 30 && rsp_log.size() == 0; i++) tick();
        check("ovf_rsp_seen", rsp_log.size(), 1);
        if (rsp_log.size() > 0) begin
            check("ovf_result", rsp_log[0].res, 16'h7C00);
            check("ovf_flags", rsp_log[0].fl, 3'b100);
            check("ovf_rsp_id", rsp_log[0].id, 1);
        end

        // Back-pressure: response held for 20 cycles with requester 1 pending.
        bus.rsp_ready = 1'b0;
        set_op(0, 16'($urandom), 16'($urandom));
        bus.req_valid[0] = 1'b1;
        for (int i = 0; i < 20 && !(m_out && cyc >= m_due); i++) tick();
        check("bp_rsp_pending", 32'(m_out && cyc >= m_due), 1);
        set_op(1, 16'($urandom), 16'($urandom));
        bus.req_valid[1] = 1'b1;
        n0 = grant_id_log.size();
        rsp_log.delete();
        repeat (20) tick();
        check("bp_no_grant", grant_id_log.size() - n0, 0);
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        check("bp_grant_after", grant_id_log.size() - n0, 1);
        if (grant_id_log.size() > n0 && rsp_log.size() > 0) begin
            check("bp_grant_id", grant_id_log[n0], 1);
            check("bp_grant_gap", grant_cyc_log[n0] - rsp_log[0].cyc, 1);
        end
        drain();

        // Reset pulsed in WAIT with cnt=4: the in-flight op is dropped and arbitration restarts at 0.
        n0 = grant_id_log.size();
        set_op(2, 16'($urandom), 16'($urandom));
        bus.req_valid[2] = 1'b1;
        wait_grants("mid_grant_seen", n0 + 1, 20);
        repeat (4) tick();
        set_op(1, 16'($urandom), 16'($urandom));
        set_op(3, 16'($urandom), 16'($urandom));
        bus.req_valid[1] = 1'b1;
        bus.req_valid[3] = 1'b1;
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        m_out = 1'b0;
        m_ptr = 0;
        @(negedge clock);
        reset = 1'b1;
        n0 = grant_id_log.size();
        tick();
        check("post_reset_grant", grant_id_log.size() - n0, 1);
        if (grant_id_log.size() > n0) check("post_reset_id", grant_id_log[n0], 1);

        // Requester 3 withdraws while 1 is in flight (pointer at 2): next grant goes to 0.
        set_op(0, 16'($urandom), 16'($urandom));
        bus.req_valid[0] = 1'b1;
        repeat (3) tick();
        bus.req_valid[3] = 1'b0;
        n0 = grant_id_log.size();
        wait_grants("skip_grant_seen", n0 + 1, 30);
        if (grant_id_log.size() > n0) check("skip_grant_id", grant_id_log[n0], 0);
        drain();

        // Randomised traffic and back-pressure against the reference timeline.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_op(i, 16'($urandom), 16'($urandom));
                    bus.req_valid[i] = 1'b1;
                end
            end
            bus.rsp_ready = 1'($urandom_range(0, 1));
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
